sram_port_arbiter: RTL and testbench

Shares the single synchronous base SRAM port between instruction fetch (IF) and the data-memory access issued from mem1, whose read data mem2 consumes one cycle later. Data requests have priority; a starvation counter guarantees IF forward progress. The block registers ownership of each in-flight read, routes returned data to the right requester and cancels fetch data on a pipeline flush.

---
 rtl/sram_port_arbiter.sv | 117 +++++++++++
 tb/tb_sram_port_arbiter.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter
// Shares one synchronous SRAM port between instruction fetch and the data
// memory stage. Data accesses win by default. A streak counter bounds how
// long fetch can be starved. A pending flag per requester steers each read
// return back to the side that issued it.

module sram_port_arbiter #(
    parameter int ADDR_W        = 20,
    parameter int MAX_DM_STREAK = 4
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              if_req_i,
    input  logic [31:0]       if_addr_i,
    input  logic              if_flush_i,
    output logic              if_gnt_o,
    output logic              if_rvalid_o,
    output logic [31:0]       if_rdata_o,

    input  logic              dm_req_i,
    input  logic              dm_we_i,
    input  logic [3:0]        dm_be_n_i,
    input  logic [31:0]       dm_addr_i,
    input  logic [31:0]       dm_wdata_i,
    output logic              dm_gnt_o,
    output logic              dm_rvalid_o,
    output logic [31:0]       dm_rdata_o,

    output logic              ram_ce_o,
    output logic              ram_we_o,
    output logic [3:0]        ram_be_n_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [31:0]       ram_wdata_o,
    input  logic [31:0]       ram_rdata_i
);

    localparam logic [3:0] STREAK_MAX = 4'(MAX_DM_STREAK);

    logic       force_if;
    logic       if_gnt;
    logic       dm_gnt;
    logic       if_pend_q;
    logic       if_pend_d;
    logic       dm_pend_q;
    logic       dm_pend_d;
    logic [3:0] streak_q;
    logic [3:0] streak_d;

    // Byte-offset bits, plus any address bits above the SRAM range, never reach the port.
    logic unused_addr_low;
    assign unused_addr_low = ^{if_addr_i[1:0], dm_addr_i[1:0]};

    generate
        if (ADDR_W < 30) begin : g_unused_upper
            logic unused_addr_high;
            assign unused_addr_high = ^{if_addr_i[31:ADDR_W+2], dm_addr_i[31:ADDR_W+2]};
        end
    endgenerate

    // Per-cycle grant decision and the SRAM command for the winning requester; reset silences the port.
    always_comb begin
        force_if = (streak_q == STREAK_MAX) & if_req_i & ~if_flush_i;
        dm_gnt   = dm_req_i & ~force_if & ~rst;
        if_gnt   = if_req_i & ~if_flush_i & (~dm_req_i | force_if) & ~rst;

        if_gnt_o    = if_gnt;
        dm_gnt_o    = dm_gnt;
        ram_ce_o    = if_gnt | dm_gnt;
        ram_we_o    = dm_gnt & dm_we_i;
        ram_addr_o  = dm_addr_i[ADDR_W+1:2];
        ram_wdata_o = dm_wdata_i;
        ram_be_n_o  = 4'b1111;

        if (if_gnt) begin
            ram_addr_o = if_addr_i[ADDR_W+1:2];
            ram_be_n_o = 4'b0000;
        end else if (dm_gnt) begin
            ram_be_n_o = dm_be_n_i;
        end
    end

    // Next-state for read ownership and the fetch starvation streak.
    always_comb begin
        if_pend_d = if_gnt;
        dm_pend_d = dm_gnt & ~dm_we_i;
        streak_d  = streak_q;

        if (if_gnt || !if_req_i || if_flush_i) begin
            streak_d = 4'd0;
        end else if (dm_gnt && if_req_i) begin
            streak_d = (streak_q == STREAK_MAX) ? STREAK_MAX : streak_q + 4'd1;
        end
    end

    // Route returning SRAM data using only the ownership flags; a flush or reset kills the return.
    always_comb begin
        if_rvalid_o = if_pend_q & ~if_flush_i & ~rst;
        dm_rvalid_o = dm_pend_q & ~rst;
        if_rdata_o  = ram_rdata_i;
        dm_rdata_o  = ram_rdata_i;
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            if_pend_q <= 1'b0;
            dm_pend_q <= 1'b0;
            streak_q  <= 4'd0;
        end else begin
            if_pend_q <= if_pend_d;
            dm_pend_q <= dm_pend_d;
            streak_q  <= streak_d;
        end
    end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed testbench for sram_port_arbiter with a behavioural SRAM and
// read-data scoreboards for each requester.

module tb_sram_port_arbiter;

    localparam int ADDR_W = 20;

    logic              clk;
    logic              rst;
    logic              if_req_i;
    logic [31:0]       if_addr_i;
    logic              if_flush_i;
    logic              if_gnt_o;
    logic              if_rvalid_o;
    logic [31:0]       if_rdata_o;
    logic              dm_req_i;
    logic              dm_we_i;
    logic [3:0]        dm_be_n_i;
    logic [31:0]       dm_addr_i;
    logic [31:0]       dm_wdata_i;
    logic              dm_gnt_o;
    logic              dm_rvalid_o;
    logic [31:0]       dm_rdata_o;
    logic              ram_ce_o;
    logic              ram_we_o;
    logic [3:0]        ram_be_n_o;
    logic [ADDR_W-1:0] ram_addr_o;
    logic [31:0]       ram_wdata_o;
    logic [31:0]       ram_rdata_i;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_if_q[$];
    logic [31:0] exp_dm_q[$];

    logic [31:0] mem [0:1023];

    sram_port_arbiter #(.ADDR_W(ADDR_W), .MAX_DM_STREAK(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .if_req_i    (if_req_i),
        .if_addr_i   (if_addr_i),
        .if_flush_i  (if_flush_i),
        .if_gnt_o    (if_gnt_o),
        .if_rvalid_o (if_rvalid_o),
        .if_rdata_o  (if_rdata_o),
        .dm_req_i    (dm_req_i),
        .dm_we_i     (dm_we_i),
        .dm_be_n_i   (dm_be_n_i),
        .dm_addr_i   (dm_addr_i),
        .dm_wdata_i  (dm_wdata_i),
        .dm_gnt_o    (dm_gnt_o),
        .dm_rvalid_o (dm_rvalid_o),
        .dm_rdata_o  (dm_rdata_o),
        .ram_ce_o    (ram_ce_o),
        .ram_we_o    (ram_we_o),
        .ram_be_n_o  (ram_be_n_o),
        .ram_addr_o  (ram_addr_o),
        .ram_wdata_o (ram_wdata_o),
        .ram_rdata_i (ram_rdata_i)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural synchronous SRAM: byte-masked writes, one-cycle read latency.
    always @(posedge clk) begin
        if (ram_ce_o) begin
            if (ram_we_o) begin
                for (int b = 0; b < 4; b++) begin
                    if (!ram_be_n_o[b]) mem[ram_addr_o[9:0]][8*b +: 8] <= ram_wdata_o[8*b +: 8];
                end
            end else begin
                ram_rdata_i <= mem[ram_addr_o[9:0]];
            end
        end
    end

    // Keeps the run bounded no matter what the DUT does.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic checkReturn(input logic exp_if, input logic exp_dm);
        logic [31:0] e;
        checkOutput("if_rvalid", {31'b0, if_rvalid_o}, {31'b0, exp_if});
        checkOutput("dm_rvalid", {31'b0, dm_rvalid_o}, {31'b0, exp_dm});
        if (exp_if) begin
            if (exp_if_q.size() == 0) begin
                checks++;
                errors++;
                $error("[TB] FAIL if_scoreboard observed=empty expected=entry");
            end else begin
                e = exp_if_q.pop_front();
                checkOutput("if_rdata", if_rdata_o, e);
            end
        end
        if (exp_dm) begin
            if (exp_dm_q.size() == 0) begin
                checks++;
                errors++;
                $error("[TB] FAIL dm_scoreboard observed=empty expected=entry");
            end else begin
                e = exp_dm_q.pop_front();
                checkOutput("dm_rdata", dm_rdata_o, e);
            end
        end
    endtask

    task automatic applyStimulus(input logic ifr, input logic [31:0] ifa, input logic fl,
                                 input logic dr, input logic we, input logic [3:0] ben,
                                 input logic [31:0] da, input logic [31:0] wd);
        if_req_i   = ifr;
        if_addr_i  = ifa;
        if_flush_i = fl;
        dm_req_i   = dr;
        dm_we_i    = we;
        dm_be_n_i  = ben;
        dm_addr_i  = da;
        dm_wdata_i = wd;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkIdlePort(input string tag);
        checkOutput({tag, "_if_gnt"}, {31'b0, if_gnt_o}, 32'd0);
        checkOutput({tag, "_dm_gnt"}, {31'b0, dm_gnt_o}, 32'd0);
        checkOutput({tag, "_ce"}, {31'b0, ram_ce_o}, 32'd0);
        checkOutput({tag, "_we"}, {31'b0, ram_we_o}, 32'd0);
        checkOutput({tag, "_be_n"}, {28'b0, ram_be_n_o}, 32'hF);
    endtask

    // Directed sequence: reset, fetch, store/load, starvation, flushes, reset mid-read.
    initial begin
        logic is_if;
        for (int i = 0; i < 1024; i++) mem[i] = 32'hC0DE0000 | 32'(i);
        mem[4]  = 32'hDEADBEEF;
        mem[32] = 32'hAAAAAAAA;

        // Reset held with both requesters active: the port must stay silent.
        rst = 1'b1;
        applyStimulus(1'b1, 32'h200, 1'b0, 1'b1, 1'b1, 4'b0000, 32'h80, 32'hFFFFFFFF);
        tick();
        @(negedge clk);
        checkIdlePort("reset");
        tick();
        rst = 1'b0;
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 4'b1111, 32'h0, 32'h0);
        @(negedge clk);
        checkReturn(1'b0, 1'b0);
        checkOutput("reset_streak", {28'b0, dut.streak_q}, 32'd0);
        checkIdlePort("post_reset");
        tick();

        // Idle to fetch.
        applyStimulus(1'b1, 32'h1C000010, 1'b0, 1'b0, 1'b0, 4'b1111, 32'h0, 32'h0);
        @(negedge clk);
        checkOutput("fetch_gnt", {31'b0, if_gnt_o}, 32'd1);
        checkOutput("fetch_dm_gnt", {31'b0, dm_gnt_o}, 32'd0);
        checkOutput("fetch_addr", {12'b0, ram_addr_o}, 32'h00004);
        checkOutput("fetch_be_n", {28'b0, ram_be_n_o}, 32'h0);
        checkOutput("fetch_ce", {31'b0, ram_ce_o}, 32'd1);
        exp_if_q.push_back(32'hDEADBEEF);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 4'b1111, 32'h0, 32'h0);
        @(negedge clk);
        checkReturn(1'b1, 1'b0);
        tick();

        // Store then load to the same word.
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 4'b1100, 32'h80, 32'h12345678);
        @(negedge clk);
        checkOutput("store_gnt", {31'b0, dm_gnt_o}, 32'd1);
        checkOutput("store_we", {31'b0, ram_we_o}, 32'd1);
        checkOutput("store_be_n", {28'b0, ram_be_n_o}, 32'hC);
        checkOutput("store_addr", {12'b0, ram_addr_o}, 32'h20);
        checkOutput("store_wdata", ram_wdata_o, 32'h12345678);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 4'b0000, 32'h80, 32'h0);
        @(negedge clk);
        checkReturn(1'b0, 1'b0);
        checkOutput("load_gnt", {31'b0, dm_gnt_o}, 32'd1);
        checkOutput("load_we", {31'b0, ram_we_o}, 32'd0);
        exp_dm_q.push_back(32'hAAAA5678);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 4'b1111, 32'h0, 32'h0);
        @(negedge clk);
        checkReturn(1'b0, 1'b1);
        checkOutput("after_load_we", {31'b0, ram_we_o}, 32'd0);
        tick();

        // Starvation guard: both sides requesting for ten cycles.
        applyStimulus(1'b1, 32'h200, 1'b0, 1'b1, 1'b0, 4'b0000, 32'h100, 32'h0);
        is_if = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i == 0) checkReturn(1'b0, 1'b0);
            else        checkReturn(is_if, ~is_if);
            is_if = ((i % 5) == 4);
            checkOutput("starve_streak", {28'b0, dut.streak_q}, 32'(i % 5));
            checkOutput("starve_if_gnt", {31'b0, if_gnt_o}, {31'b0, is_if});
            checkOutput("starve_dm_gnt", {31'b0, dm_gnt_o}, {31'b0, ~is_if});
            checkOutput("starve_addr", {12'b0, ram_addr_o}, is_if ? 32'h80 : 32'h40);
            if (is_if) exp_if_q.push_back(32'hC0DE0080);
            else       exp_dm_q.push_back(32'hC0DE0040);
            tick();
        end
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 4'b1111, 32'h0, 32'h0);
        @(negedge clk);
        checkReturn(1'b1, 1'b0);
        checkOutput("starve_end_streak", {28'b0, dut.streak_q}, 32'd0);
        tick();

        // Flush in the return cycle while a data load is granted.
        applyStimulus(1'b1, 32'h200, 1'b0, 1'b0, 1'b0, 4'b1111, 32'h0, 32'h0);
        @(negedge clk);
        checkOutput("rflush_if_gnt", {31'b0, if_gnt_o}, 32'd1);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 4'b0000, 32'h100, 32'h0);
        @(negedge clk);
        checkReturn(1'b0, 1'b0);
        checkOutput("rflush_dm_gnt", {31'b0, dm_gnt_o}, 32'd1);
        exp_dm_q.push_back(32'hC0DE0040);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 4'b1111, 32'h0, 32'h0);
        @(negedge clk);
        checkReturn(1'b0, 1'b1);
        tick();

        // Flush in the grant cycle after building a nonzero streak.
        applyStimulus(1'b1, 32'h200, 1'b0, 1'b1, 1'b0, 4'b0000, 32'h100, 32'h0);
        @(negedge clk);
        checkOutput("gflush_pre_dm_gnt", {31'b0, dm_gnt_o}, 32'd1);
        exp_dm_q.push_back(32'hC0DE0040);
        tick();
        applyStimulus(1'b1, 32'h200, 1'b1, 1'b0, 1'b0, 4'b1111, 32'h0, 32'h0);
        @(negedge clk);
        checkOutput("gflush_streak_in", {28'b0, dut.streak_q}, 32'd1);
        checkIdlePort("gflush");
        checkReturn(1'b0, 1'b1);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 4'b1111, 32'h0, 32'h0);
        @(negedge clk);
        checkOutput("gflush_streak_out", {28'b0, dut.streak_q}, 32'd0);
        checkReturn(1'b0, 1'b0);
        tick();

        // Reset arriving while a load is in flight.
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 4'b0000, 32'h100, 32'h0);
        @(negedge clk);
        checkOutput("rstrd_dm_gnt", {31'b0, dm_gnt_o}, 32'd1);
        tick();
        rst = 1'b1;
        applyStimulus(1'b1, 32'h200, 1'b0, 1'b1, 1'b0, 4'b0000, 32'h100, 32'h0);
        @(negedge clk);
        checkReturn(1'b0, 1'b0);
        checkIdlePort("rstrd");
        tick();
        rst = 1'b0;
        applyStimulus(1'b1, 32'h200, 1'b0, 1'b0, 1'b0, 4'b1111, 32'h0, 32'h0);
        @(negedge clk);
        checkReturn(1'b0, 1'b0);
        checkOutput("rstrd_resume_gnt", {31'b0, if_gnt_o}, 32'd1);
        checkOutput("rstrd_resume_addr", {12'b0, ram_addr_o}, 32'h80);
        exp_if_q.push_back(32'hC0DE0080);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 4'b1111, 32'h0, 32'h0);
        @(negedge clk);
        checkReturn(1'b1, 1'b0);
        tick();

        checkOutput("if_sb_drained", 32'(exp_if_q.size()), 32'd0);
        checkOutput("dm_sb_drained", 32'(exp_dm_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
